// File: rtl/spi_seq_pkg.sv
// Shared definitions for the CoreSPI transfer sequencer: register map,
// STAT bit positions and the state encodings of the sequencer and APB engine.
package spi_seq_pkg;

    localparam logic [6:0] ADDR_CTRL1       = 7'h00;
    localparam logic [6:0] ADDR_RXDATA      = 7'h08;
    localparam logic [6:0] ADDR_TXDATA      = 7'h0C;
    localparam logic [6:0] ADDR_STAT        = 7'h20;
    localparam logic [6:0] ADDR_SSEL        = 7'h24;
    localparam logic [6:0] ADDR_TXDATA_LAST = 7'h28;

    localparam int STAT_RXEMPTY = 2;
    localparam int STAT_TXFULL  = 3;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEL,
        ST_POLL_TXF,
        ST_LOAD,
        ST_WR_TX,
        ST_POLL_RXE,
        ST_RD_RX,
        ST_OUT,
        ST_DESEL
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } apb_phase_e;

    // One-hot slave select word as CoreSPI expects it in the SSEL register.
    function automatic logic [31:0] sselOneHot(input logic [2:0] idx);
        sselOneHot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer_apb.sv
// Single-access APB master engine. A request is latched when the engine is
// idle, then driven through setup and access phases; done_o pulses in the
// cycle PREADY is seen so the caller can sample rdata_o/slverr_o directly.
module apb_master_port
    import spi_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [6:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        write_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        slverr_o,
    output logic [6:0]  paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    apb_phase_e  phase_q, phase_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;

    // Phase register; reset abandons any access in flight so PSEL drops next cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Latch the request on entry to setup so address/data stay stable through access.
    always_comb begin
        phase_d = phase_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        unique case (phase_q)
            PH_IDLE: begin
                if (req_i) begin
                    phase_d = PH_SETUP;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    write_d = write_i;
                end
            end
            PH_SETUP:  phase_d = PH_ACCESS;
            PH_ACCESS: begin
                if (pready_i) begin
                    phase_d = PH_IDLE;
                end
            end
            default:   phase_d = PH_IDLE;
        endcase
    end

    assign psel_o    = (phase_q != PH_IDLE);
    assign penable_o = (phase_q == PH_ACCESS);
    assign paddr_o   = addr_q;
    assign pwrite_o  = write_q;
    assign pwdata_o  = wdata_q;
    assign done_o    = (phase_q == PH_ACCESS) && pready_i;
    assign rdata_o   = prdata_i;
    assign slverr_o  = done_o && pslverr_i;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Command-driven SPI transfer sequencer in front of CoreSPI. Runs a whole
// select / TX / dummy-RX / deselect transfer through APB register accesses,
// keeping exactly one frame in flight at a time.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int         TXLEN_W    = 8,
    parameter int         POLL_LIMIT = 4096,
    parameter logic [7:0] CTRL1_INIT = 8'h03
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_ssel,
    input  logic [TXLEN_W-1:0] cmd_tx_len,
    input  logic [TXLEN_W-1:0] cmd_rx_len,
    input  logic               tx_valid,
    input  logic [7:0]         tx_data,
    output logic               tx_ready,
    output logic               rx_valid,
    output logic [7:0]         rx_data,
    input  logic               rx_ready,
    output logic               busy,
    output logic               err,
    output logic [6:0]         PADDR,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int                 PCW      = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0]     POLL_MAX = PCW'(POLL_LIMIT);
    localparam logic [PCW-1:0]     POLL_ONE = PCW'(1);
    localparam logic [TXLEN_W-1:0] LEN_ONE  = TXLEN_W'(1);

    seq_state_e         state_q, state_d;
    logic [TXLEN_W-1:0] txLeft_q, txLeft_d;
    logic [TXLEN_W-1:0] rxLeft_q, rxLeft_d;
    logic [2:0]         ssel_q, ssel_d;
    logic [7:0]         txByte_q, txByte_d;
    logic [7:0]         rxByte_q, rxByte_d;
    logic               frameIsRx_q, frameIsRx_d;
    logic               err_q, err_d;
    logic [PCW-1:0]     pollCnt_q, pollCnt_d;

    logic               apbReq;
    logic               apbWrite;
    logic [6:0]         apbAddr;
    logic [31:0]        apbWdata;
    logic [31:0]        apbRdata;
    logic               apbDone;
    logic               apbSlverr;

    logic               lastFrame;
    logic               pollExpired;
    seq_state_e         nextFrameState;
    logic               unusedRdataBits;

    apb_master_port u_apb (
        .clk_i     (PCLK),
        .reset_i   (PRESET),
        .req_i     (apbReq),
        .addr_i    (apbAddr),
        .wdata_i   (apbWdata),
        .write_i   (apbWrite),
        .done_o    (apbDone),
        .rdata_o   (apbRdata),
        .slverr_o  (apbSlverr),
        .paddr_o   (PADDR),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .pwdata_o  (PWDATA),
        .prdata_i  (PRDATA),
        .pready_i  (PREADY),
        .pslverr_i (PSLVERR)
    );

    // The final frame of a command goes to TXDATA_LAST so CoreSPI can release the bus cleanly.
    assign lastFrame      = frameIsRx_q ? (rxLeft_q == LEN_ONE)
                                        : ((txLeft_q == LEN_ONE) && (rxLeft_q == '0));
    assign pollExpired    = (pollCnt_q == POLL_MAX);
    assign nextFrameState = ((txLeft_q != '0) || (rxLeft_q != '0)) ? ST_POLL_TXF : ST_DESEL;
    assign unusedRdataBits = ^apbRdata[31:8];

    // Sequencer state and datapath registers; reset restarts at CTRL1 programming.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_INIT;
            txLeft_q    <= '0;
            rxLeft_q    <= '0;
            ssel_q      <= '0;
            txByte_q    <= '0;
            rxByte_q    <= '0;
            frameIsRx_q <= 1'b0;
            err_q       <= 1'b0;
            pollCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            txLeft_q    <= txLeft_d;
            rxLeft_q    <= rxLeft_d;
            ssel_q      <= ssel_d;
            txByte_q    <= txByte_d;
            rxByte_q    <= rxByte_d;
            frameIsRx_q <= frameIsRx_d;
            err_q       <= err_d;
            pollCnt_q   <= pollCnt_d;
        end
    end

    // Next-state logic and APB request selection for each step of a transfer.
    always_comb begin
        state_d     = state_q;
        txLeft_d    = txLeft_q;
        rxLeft_d    = rxLeft_q;
        ssel_d      = ssel_q;
        txByte_d    = txByte_q;
        rxByte_d    = rxByte_q;
        frameIsRx_d = frameIsRx_q;
        err_d       = err_q;
        pollCnt_d   = pollExpired ? pollCnt_q : (pollCnt_q + POLL_ONE);
        apbReq      = 1'b0;
        apbWrite    = 1'b0;
        apbAddr     = '0;
        apbWdata    = '0;

        unique case (state_q)
            ST_INIT: begin
                apbReq   = 1'b1;
                apbWrite = 1'b1;
                apbAddr  = ADDR_CTRL1;
                apbWdata = {24'h0, CTRL1_INIT};
                if (apbDone) begin
                    if (apbSlverr) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    err_d    = 1'b0;
                    txLeft_d = cmd_tx_len;
                    rxLeft_d = cmd_rx_len;
                    ssel_d   = cmd_ssel;
                    if ((cmd_tx_len != '0) || (cmd_rx_len != '0)) begin
                        state_d = ST_SEL;
                    end
                end
            end
            ST_SEL: begin
                apbReq   = 1'b1;
                apbWrite = 1'b1;
                apbAddr  = ADDR_SSEL;
                apbWdata = sselOneHot(ssel_q);
                if (apbDone) begin
                    if (apbSlverr) begin
                        err_d   = 1'b1;
                        state_d = ST_DESEL;
                    end else begin
                        state_d = ST_POLL_TXF;
                    end
                end
            end
            ST_POLL_TXF: begin
                apbReq  = 1'b1;
                apbAddr = ADDR_STAT;
                if (apbDone) begin
                    if (apbSlverr || (apbRdata[STAT_TXFULL] && pollExpired)) begin
                        err_d   = 1'b1;
                        state_d = ST_DESEL;
                    end else if (!apbRdata[STAT_TXFULL]) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (txLeft_q != '0) begin
                    if (tx_valid) begin
                        txByte_d    = tx_data;
                        frameIsRx_d = 1'b0;
                        state_d     = ST_WR_TX;
                    end
                end else begin
                    txByte_d    = 8'h00;
                    frameIsRx_d = 1'b1;
                    state_d     = ST_WR_TX;
                end
            end
            ST_WR_TX: begin
                apbReq   = 1'b1;
                apbWrite = 1'b1;
                apbAddr  = lastFrame ? ADDR_TXDATA_LAST : ADDR_TXDATA;
                apbWdata = {24'h0, txByte_q};
                if (apbDone) begin
                    if (apbSlverr) begin
                        err_d   = 1'b1;
                        state_d = ST_DESEL;
                    end else begin
                        if (frameIsRx_q) begin
                            if (rxLeft_q != '0) begin
                                rxLeft_d = rxLeft_q - LEN_ONE;
                            end
                        end else begin
                            if (txLeft_q != '0) begin
                                txLeft_d = txLeft_q - LEN_ONE;
                            end
                        end
                        state_d = ST_POLL_RXE;
                    end
                end
            end
            ST_POLL_RXE: begin
                apbReq  = 1'b1;
                apbAddr = ADDR_STAT;
                if (apbDone) begin
                    if (apbSlverr || (apbRdata[STAT_RXEMPTY] && pollExpired)) begin
                        err_d   = 1'b1;
                        state_d = ST_DESEL;
                    end else if (!apbRdata[STAT_RXEMPTY]) begin
                        state_d = ST_RD_RX;
                    end
                end
            end
            ST_RD_RX: begin
                apbReq  = 1'b1;
                apbAddr = ADDR_RXDATA;
                if (apbDone) begin
                    if (apbSlverr) begin
                        err_d   = 1'b1;
                        state_d = ST_DESEL;
                    end else if (frameIsRx_q) begin
                        rxByte_d = apbRdata[7:0];
                        state_d  = ST_OUT;
                    end else begin
                        state_d = nextFrameState;
                    end
                end
            end
            ST_OUT: begin
                if (rx_ready) begin
                    state_d = nextFrameState;
                end
            end
            ST_DESEL: begin
                apbReq   = 1'b1;
                apbWrite = 1'b1;
                apbAddr  = ADDR_SSEL;
                apbWdata = 32'h0;
                if (apbDone) begin
                    if (apbSlverr) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if ((state_d != state_q) && ((state_d == ST_POLL_TXF) || (state_d == ST_POLL_RXE))) begin
            pollCnt_d = '0;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign tx_ready  = (state_q == ST_LOAD) && (txLeft_q != '0);
    assign rx_valid  = (state_q == ST_OUT);
    assign rx_data   = rxByte_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_INIT);
    assign err       = err_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: a CoreSPI-like APB slave model
// with random wait states, scoreboard queues for expected APB writes and RX
// bytes, and a linear sequence of directed scenarios.
module tb_spi_xfer_sequencer;
    import spi_seq_pkg::*;

    localparam int POLL_LIMIT = 100;
    localparam int MAX_WAIT   = 5;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ssel = '0;
    logic [7:0]  cmd_tx_len = '0;
    logic [7:0]  cmd_rx_len = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        busy;
    logic        err;
    logic [6:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vectors = 0;
    int miscompares = 0;

    logic [38:0] expWr[$];
    logic [7:0]  expRx[$];
    logic [7:0]  txFeed[$];
    logic [7:0]  slaveRx[$];
    logic [7:0]  txBytes[$];
    logic [7:0]  slaveBytes[$];

    bit          stuckFull = 1'b0;
    bit          holdReady = 1'b0;
    logic [6:0]  errAddr = 7'h7F;
    int          waitLeft = 0;
    logic [6:0]  setupAddr = '0;
    logic [31:0] setupData = '0;
    int          rxStall = 0;
    int          stallCycles = 0;
    int          stallPsel = 0;
    int          rxCount = 0;
    int          wrCount = 0;

    always #5 PCLK = ~PCLK;

    spi_xfer_sequencer #(
        .TXLEN_W    (8),
        .POLL_LIMIT (POLL_LIMIT),
        .CTRL1_INIT (8'h03)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ssel   (cmd_ssel),
        .cmd_tx_len (cmd_tx_len),
        .cmd_rx_len (cmd_rx_len),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .err        (err),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // APB slave model: random wait states, write scoreboard, STAT/RXDATA read responses.
    initial begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        forever begin
            @(negedge PCLK);
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            if (PSEL && !PENABLE) begin
                waitLeft  = $urandom_range(0, MAX_WAIT);
                setupAddr = PADDR;
                setupData = PWDATA;
            end else if (PSEL && PENABLE && !holdReady) begin
                if (waitLeft > 0) begin
                    waitLeft--;
                end else begin
                    PREADY = 1'b1;
                    checkOutput("apb_stable", 64'({PWRITE, PADDR, PWDATA}), 64'({PWRITE, setupAddr, setupData}));
                    if (PWRITE) begin
                        wrCount++;
                        if (PADDR == errAddr) begin
                            PSLVERR = 1'b1;
                            errAddr = 7'h7F;
                        end
                        checkOutput("apb_wr_pending", 64'(expWr.size() != 0), 64'(1));
                        if (expWr.size() != 0) begin
                            checkOutput("apb_write", 64'({PADDR, PWDATA}), 64'(expWr.pop_front()));
                        end
                    end else if (PADDR == ADDR_STAT) begin
                        PRDATA = (stuckFull ? 32'h8 : 32'h0) | (($urandom_range(0, 2) == 0) ? 32'h4 : 32'h0);
                    end else if (PADDR == ADDR_RXDATA) begin
                        if (slaveRx.size() != 0) begin
                            PRDATA = {24'h0, slaveRx.pop_front()};
                        end else begin
                            PRDATA = 32'hEE;
                        end
                    end else begin
                        PRDATA = 32'h0;
                    end
                end
            end
        end
    end

    // TX byte source fed from the txFeed queue.
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge PCLK);
            if (txFeed.size() != 0) begin
                tx_valid = 1'b1;
                tx_data  = txFeed[0];
                if (tx_ready) begin
                    void'(txFeed.pop_front());
                end
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    // RX byte sink with optional back-pressure; compares against the expected RX queue.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(negedge PCLK);
            if (rx_valid && (rxStall > 0)) begin
                rx_ready = 1'b0;
                rxStall--;
                stallCycles++;
                if (PSEL) begin
                    stallPsel++;
                end
            end else begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    rxCount++;
                    checkOutput("rx_pending", 64'(expRx.size() != 0), 64'(1));
                    if (expRx.size() != 0) begin
                        checkOutput("rx_data", 64'(rx_data), 64'(expRx.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendCmd(input logic [2:0] ssel, input int txl, input int rxl);
        int n;
        @(negedge PCLK);
        cmd_valid  = 1'b1;
        cmd_ssel   = ssel;
        cmd_tx_len = 8'(txl);
        cmd_rx_len = 8'(rxl);
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("cmd_accept", 64'(cmd_ready), 64'(1));
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge PCLK);
        while (!(cmd_ready && !busy) && n < 5000) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("idle_reached", 64'(cmd_ready && !busy), 64'(1));
    endtask

    // Push the full expected write/RX sequence for a clean transfer, then issue it.
    task automatic applyStimulus(input logic [2:0] ssel, input int txl, input int rxl);
        int total;
        total = txl + rxl;
        expWr.push_back({ADDR_SSEL, 32'd1 << ssel});
        for (int i = 0; i < total; i++) begin
            logic [7:0] b;
            b = (i < txl) ? txBytes[i] : 8'h00;
            if (i < txl) begin
                txFeed.push_back(b);
            end
            expWr.push_back({(i == total - 1) ? ADDR_TXDATA_LAST : ADDR_TXDATA, 24'h0, b});
            slaveRx.push_back(slaveBytes[i]);
            if (i >= txl) begin
                expRx.push_back(slaveBytes[i]);
            end
        end
        expWr.push_back({ADDR_SSEL, 32'h0});
        sendCmd(ssel, txl, rxl);
    endtask

    initial begin
        int rxBefore;
        int wrBefore;
        int idleBusy;
        int errCycles;
        int n;

        // Reset state
        repeat (3) @(negedge PCLK);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        checkOutput("rst_psel", 64'(PSEL), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        checkOutput("rst_rx_valid", 64'(rx_valid), 64'(0));
        checkOutput("rst_tx_ready", 64'(tx_ready), 64'(0));
        expWr.push_back({ADDR_CTRL1, 32'h3});
        PRESET = 1'b0;
        waitIdle();
        checkOutput("init_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("init_wr_count", 64'(wrCount), 64'(1));

        // TX-only transfer
        $display("[TB] tx-only transfer");
        rxBefore = rxCount;
        txBytes = '{8'hA5, 8'h3C};
        slaveBytes = '{8'h55, 8'h66};
        applyStimulus(3'd1, 2, 0);
        waitIdle();
        checkOutput("txonly_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("txonly_no_rx", 64'(rxCount), 64'(rxBefore));
        checkOutput("txonly_err", 64'(err), 64'(0));

        // TX + RX transfer with consumer back-pressure
        $display("[TB] tx+rx transfer with stall");
        rxBefore = rxCount;
        txBytes = '{8'h7E};
        slaveBytes = '{8'h11, 8'h22, 8'h33};
        stallCycles = 0;
        stallPsel = 0;
        rxStall = 10;
        applyStimulus(3'd4, 1, 2);
        waitIdle();
        checkOutput("txrx_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("txrx_rx_left", 64'(expRx.size()), 64'(0));
        checkOutput("txrx_rx_count", 64'(rxCount - rxBefore), 64'(2));
        checkOutput("stall_cycles", 64'(stallCycles), 64'(10));
        checkOutput("stall_psel", 64'(stallPsel), 64'(0));

        // Zero-length command is consumed without APB traffic
        $display("[TB] zero-length command");
        wrBefore = wrCount;
        sendCmd(3'd2, 0, 0);
        idleBusy = 0;
        repeat (6) begin
            @(negedge PCLK);
            if (busy || PSEL || !cmd_ready) begin
                idleBusy++;
            end
        end
        checkOutput("zero_no_activity", 64'(idleBusy), 64'(0));
        checkOutput("zero_no_writes", 64'(wrCount), 64'(wrBefore));

        // TX FIFO stuck full: poll timeout
        $display("[TB] poll timeout");
        stuckFull = 1'b1;
        expWr.push_back({ADDR_SSEL, 32'h1});
        expWr.push_back({ADDR_SSEL, 32'h0});
        txFeed.push_back(8'h99);
        sendCmd(3'd0, 1, 0);
        errCycles = 0;
        while (!err && errCycles < 2000) begin
            @(negedge PCLK);
            errCycles++;
        end
        checkOutput("timeout_err", 64'(err), 64'(1));
        checkOutput("timeout_not_early", 64'(errCycles >= POLL_LIMIT), 64'(1));
        checkOutput("timeout_not_late", 64'(errCycles <= POLL_LIMIT + 30), 64'(1));
        waitIdle();
        checkOutput("timeout_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("timeout_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("timeout_err_sticky", 64'(err), 64'(1));
        checkOutput("timeout_tx_unused", 64'(txFeed.size()), 64'(1));
        stuckFull = 1'b0;
        txFeed.delete();

        // PSLVERR on a TXDATA write
        $display("[TB] slave error on TXDATA");
        errAddr = ADDR_TXDATA;
        expWr.push_back({ADDR_SSEL, 32'h4});
        expWr.push_back({ADDR_TXDATA, 32'h12});
        expWr.push_back({ADDR_SSEL, 32'h0});
        txFeed.push_back(8'h12);
        txFeed.push_back(8'h34);
        sendCmd(3'd2, 2, 0);
        waitIdle();
        checkOutput("slverr_err", 64'(err), 64'(1));
        checkOutput("slverr_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("slverr_tx_unused", 64'(txFeed.size()), 64'(1));
        txFeed.delete();
        txBytes = '{8'h42};
        slaveBytes = '{8'h77, 8'h88};
        applyStimulus(3'd5, 1, 1);
        checkOutput("slverr_err_cleared", 64'(err), 64'(0));
        waitIdle();
        checkOutput("recover_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("recover_rx_left", 64'(expRx.size()), 64'(0));

        // Longer mixed transfer with random data
        $display("[TB] random mixed transfer");
        txBytes.delete();
        slaveBytes.delete();
        for (int i = 0; i < 6; i++) begin
            txBytes.push_back(8'($urandom_range(0, 255)));
            slaveBytes.push_back(8'($urandom_range(0, 255)));
        end
        applyStimulus(3'd7, 3, 3);
        waitIdle();
        checkOutput("rand_wr_left", 64'(expWr.size()), 64'(0));
        checkOutput("rand_rx_left", 64'(expRx.size()), 64'(0));
        checkOutput("rand_err", 64'(err), 64'(0));

        // Reset in the middle of an access phase
        $display("[TB] reset during access");
        holdReady = 1'b1;
        txFeed.push_back(8'h5A);
        sendCmd(3'd3, 1, 0);
        n = 0;
        while (!(PSEL && PENABLE) && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("midrst_in_access", 64'(PSEL && PENABLE), 64'(1));
        PRESET = 1'b1;
        @(negedge PCLK);
        checkOutput("midrst_psel", 64'(PSEL), 64'(0));
        checkOutput("midrst_penable", 64'(PENABLE), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
        holdReady = 1'b0;
        txFeed.delete();
        slaveRx.delete();
        wrBefore = wrCount;
        expWr.push_back({ADDR_CTRL1, 32'h3});
        @(negedge PCLK);
        PRESET = 1'b0;
        waitIdle();
        checkOutput("midrst_init_write", 64'(wrCount - wrBefore), 64'(1));
        checkOutput("midrst_wr_left", 64'(expWr.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
